// File: rtl/decoder_hold_if.sv
// Request/response bundle for decoder_hold: code + handshake in, decoded lines and status out.
interface decoder_hold_if;
   logic [2:0] d;
   logic       d_vld;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] o;
   logic       busy;
   logic       done;
   logic       nodrv;
   logic [7:0] cnt;

   modport master (
      output d, d_vld, in_valid,
      input  in_ready, o, busy, done, nodrv, cnt
   );

   modport slave (
      input  d, d_vld, in_valid,
      output in_ready, o, busy, done, nodrv, cnt
   );
endinterface

// File: rtl/decoder_hold.sv
// 3-to-8 decoder whose accepted line is held for HOLD cycles, followed by GAP idle cycles.
module decoder_hold #(
   parameter int unsigned HOLD = 4,
   parameter int unsigned GAP  = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   decoder_hold_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
   localparam bit         HAS_GAP = (GAP != 0);
   localparam logic [3:0] GAP_LD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] o_q, o_d;
   logic [7:0] cnt_q, cnt_d;
   logic       nodrv_q, nodrv_d;
   logic [7:0] line_dec;

   // An unknown code falls to the default arm, so o never picks up X.
   always_comb begin
      line_dec = '0;
      case (bus.d)
         3'd0:    line_dec = 8'h01;
         3'd1:    line_dec = 8'h02;
         3'd2:    line_dec = 8'h04;
         3'd3:    line_dec = 8'h08;
         3'd4:    line_dec = 8'h10;
         3'd5:    line_dec = 8'h20;
         3'd6:    line_dec = 8'h40;
         3'd7:    line_dec = 8'h80;
         default: line_dec = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         gap_q   <= '0;
         o_q     <= '0;
         cnt_q   <= '0;
         nodrv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         o_q     <= o_d;
         cnt_q   <= cnt_d;
         nodrv_q <= nodrv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      o_d     = o_q;
      cnt_d   = cnt_q;
      nodrv_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_d = '0;
            if (bus.in_valid) begin
               if (bus.d_vld) begin
                  o_d     = line_dec;
                  hold_d  = HOLD_LD;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_HOLD;
               end else begin
                  nodrv_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (hold_q == '0) begin
               o_d = '0;
               if (HAS_GAP) begin
                  gap_d   = GAP_LD;
                  state_d = S_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         S_GAP: begin
            o_d = '0;
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            o_d     = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready = (state_q == S_IDLE);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_HOLD) && (hold_q == '0);
   assign bus.o        = o_q;
   assign bus.nodrv    = nodrv_q;
   assign bus.cnt      = cnt_q;

endmodule

// File: doc/decoder_hold.md
DECODER_HOLD -- requirements
Module: decoder_hold

Parameters
REQ-001 HOLD, default 4: number of clock cycles a decoded output line stays asserted; legal range 1..255.
REQ-002 GAP, default 1: forced idle cycles between end of one pulse and next acceptance; legal range 0..15.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 d  input  3  binary line code, 3'b000..3'b111, selects output line 0..7.
REQ-006 d_vld  input  1  code-present flag; low = "no line active" (encoder all-zero input case).
REQ-007 in_valid  input  1  request strobe; transfer occurs on in_valid && in_ready at a rising edge.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 o  output  8  one-hot decoded lines, registered.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking last cycle of a decoded pulse.
REQ-012 nodrv  output  1  one-cycle pulse when an accepted request has d_vld=0.
REQ-013 cnt  output  8  count of decoded pulses issued.

Function
REQ-014 The FSM has exactly three states: IDLE, HOLD, GAP.
REQ-015 in_ready is combinationally high in IDLE only; low in HOLD and GAP.
REQ-016 Accept in IDLE with d_vld=1: next cycle o = 8'b1 << d, state HOLD, hold counter loaded HOLD-1.
REQ-017 Accept in IDLE with d_vld=0: o stays 8'h00, nodrv=1 for the next cycle only, state stays IDLE, cnt unchanged; d is ignored.
REQ-018 o has at most one bit set in any cycle; o = 8'h00 in IDLE and GAP.
REQ-019 HOLD: hold counter decrements each cycle; o is held constant; d, d_vld, in_valid are ignored.
REQ-020 done = 1 exactly in the HOLD cycle where the hold counter is 0, so o is high for exactly HOLD consecutive cycles.
REQ-021 Leaving HOLD: o <= 8'h00; next state GAP with gap counter GAP-1 if GAP>0, else IDLE directly.
REQ-022 GAP: gap counter decrements; on reaching 0 the next state is IDLE; GAP occupies exactly GAP cycles.
REQ-023 Minimum request-to-request spacing for decoded requests is 1+HOLD+GAP cycles; back-to-back accepts possible only for d_vld=0 requests.
REQ-024 HOLD=1: o high for one cycle, done coincident with that cycle.
REQ-025 cnt increments by 1 on every accepted d_vld=1 request, on the same edge o is set; 8'hFF wraps to 8'h00.
REQ-026 in_valid asserted outside IDLE is not accepted and is not queued; requester holds in_valid until in_ready.
REQ-027 No X/Z is ever driven on o; unknown/no-code conditions map to 8'h00.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, o=8'h00, busy=0, done=0, nodrv=0, cnt=8'h00, both counters 0.
REQ-029 Reset asserted mid-HOLD or mid-GAP aborts the pulse immediately, with no done pulse and no cnt change reverted.
REQ-030 After rst_n deasserts, in_ready=1 on the first clock cycle.

Verification
REQ-031 Defaults, reset, then d=3'b111,d_vld=1,in_valid 1 cycle -> o=8'h80 for 4 cycles, done on 4th, busy 5 cycles (4 HOLD+1 GAP), cnt=1.
REQ-032 d=3'b010,d_vld=1 held with in_valid continuously high -> accepts every 6 cycles, o=8'h04 pattern 4 on / 2 off, cnt increments each accept.
REQ-033 d_vld=0, d=3'b101, in_valid 3 consecutive cycles -> o stays 8'h00, nodrv high 3 cycles, in_ready stays 1, cnt unchanged.
REQ-034 Sweep d=0..7 with valid requests -> o equals 8'h01,02,04,...,80 in order; cnt=8; never more than one bit set.
REQ-035 rst_n pulled low in 2nd HOLD cycle of d=3'b011 -> o=8'h00 immediately (asynchronous), no done, in_ready=1 after release.
REQ-036 HOLD=1,GAP=0 build; 256 valid requests -> o pulses one cycle each, done coincident, cnt wraps to 8'h00.
